// File: rtl/snes_pad_pkg.sv
// Shared constants and types for the SNES controller-port responder.
// Button bit positions follow the order in which the console reads them.
package snes_pad_pkg;

  localparam int PAD_BITS = 16;
  localparam int BTN_BITS = 12;
  localparam int CNT_BITS = 5;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam logic [3:0]          PAD_ID   = 4'b0000;
  localparam logic [CNT_BITS-1:0] CNT_DONE = 5'd16;

  typedef enum logic [1:0] {
    UNIT_LATCH = 2'd0,
    UNIT_SHIFT = 2'd1,
    UNIT_DONE  = 2'd2
  } unit_state_e;

  function automatic logic [PAD_BITS-1:0] report_word(input logic [BTN_BITS-1:0] btn);
    return {PAD_ID, btn};
  endfunction

endpackage

// File: rtl/snes_pad_shifter.sv
// One report shifter: 16-bit word, count saturating at 16, current serial bit.
// The unit state is derived each cycle from the load request and the count.
module snes_pad_shifter
  import snes_pad_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                advance,
  input  logic [BTN_BITS-1:0] buttons,
  output logic                cur_bit
);

  logic [PAD_BITS-1:0] shreg_r, shreg_nxt_s;
  logic [CNT_BITS-1:0] cnt_r, cnt_nxt_s;
  unit_state_e         state_s;

  // Derive unit state from strobe and count
  always_comb begin
    state_s = UNIT_DONE;
    if (load) begin
      state_s = UNIT_LATCH;
    end else if (cnt_r < CNT_DONE) begin
      state_s = UNIT_SHIFT;
    end else begin
      state_s = UNIT_DONE;
    end
  end

  // Next register and count per state
  always_comb begin
    shreg_nxt_s = shreg_r;
    cnt_nxt_s   = cnt_r;
    case (state_s)
      UNIT_LATCH: begin
        shreg_nxt_s = report_word(buttons);
        cnt_nxt_s   = 5'd0;
      end
      UNIT_SHIFT: begin
        if (advance) begin
          shreg_nxt_s = {1'b1, shreg_r[PAD_BITS-1:1]};
          cnt_nxt_s   = cnt_r + 5'd1;
        end else begin
          shreg_nxt_s = shreg_r;
          cnt_nxt_s   = cnt_r;
        end
      end
      UNIT_DONE: begin
        shreg_nxt_s = shreg_r;
        cnt_nxt_s   = cnt_r;
      end
      default: begin
        shreg_nxt_s = shreg_r;
        cnt_nxt_s   = CNT_DONE;
      end
    endcase
  end

  // State register; reset parks the unit in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r <= 16'h0000;
      cnt_r   <= CNT_DONE;
    end else begin
      shreg_r <= shreg_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign cur_bit = (cnt_r >= CNT_DONE) ? 1'b1 : shreg_r[0];

endmodule

// File: rtl/snes_pad_responder.sv
// SNES controller-port responder: answers latch/clock reads with 16-bit pad
// reports, either as one standard pad or as a 4-pad multitap.
module snes_pad_responder
  import snes_pad_pkg::*;
#(
  parameter int MULTITAP = 0
) (
  input  logic                MCLK,
  input  logic                RESET,
  input  logic                JOY_STRB,
  input  logic                JOY_CLK,
  input  logic                JOY_P6,
  input  logic [BTN_BITS-1:0] PAD0,
  input  logic [BTN_BITS-1:0] PAD1,
  input  logic [BTN_BITS-1:0] PAD2,
  input  logic [BTN_BITS-1:0] PAD3,
  output logic [1:0]          JOY_DI
);

  localparam int NUM_UNITS = (MULTITAP != 0) ? 4 : 1;

  logic       clk_q_r;
  logic       rise_s;
  logic [3:0] adv_s;
  logic [3:0] bits_s;
  logic [1:0] di_nxt_s;
  logic       unused_pads_s;

  assign unused_pads_s = ^{PAD1, PAD2, PAD3, adv_s, JOY_P6};

  // Console clock history for rising-edge detection (idles high)
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      clk_q_r <= 1'b1;
    end else begin
      clk_q_r <= JOY_CLK;
    end
  end

  assign rise_s = JOY_CLK & ~clk_q_r;

  // Pick which units advance; a latch in the same cycle takes priority
  always_comb begin
    adv_s = 4'b0000;
    if (rise_s && !JOY_STRB) begin
      if (MULTITAP == 0) begin
        adv_s = 4'b0001;
      end else if (JOY_P6) begin
        adv_s = 4'b0011;
      end else begin
        adv_s = 4'b1100;
      end
    end else begin
      adv_s = 4'b0000;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_units
    if (i < NUM_UNITS) begin : g_unit
      snes_pad_shifter u_shifter (
        .clk     (MCLK),
        .rst     (RESET),
        .load    (JOY_STRB),
        .advance (adv_s[i]),
        .buttons ((i == 0) ? PAD0 : (i == 1) ? PAD1 : (i == 2) ? PAD2 : PAD3),
        .cur_bit (bits_s[i])
      );
    end else begin : g_absent
      assign bits_s[i] = 1'b1;
    end
  end

  // Data-line mapping; D1 high during latch is the multitap signature
  always_comb begin
    di_nxt_s = 2'b00;
    if (MULTITAP == 0) begin
      di_nxt_s = {1'b0, JOY_STRB ? PAD0[BTN_B] : bits_s[0]};
    end else if (JOY_STRB) begin
      di_nxt_s = {1'b1, PAD0[BTN_B]};
    end else if (JOY_P6) begin
      di_nxt_s = {bits_s[1], bits_s[0]};
    end else begin
      di_nxt_s = {bits_s[3], bits_s[2]};
    end
  end

  // Registered data lines
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      JOY_DI <= 2'b00;
    end else begin
      JOY_DI <= di_nxt_s;
    end
  end

endmodule

// File: tb/tb_snes_pad_responder.sv
// Scoreboard bench: drives a standard-pad and a multitap responder side by side
// and checks both against a read-position model of the controller protocol.
module tb_snes_pad_responder;

  logic        MCLK = 1'b0;
  logic        RESET, JOY_STRB, JOY_CLK, JOY_P6;
  logic [11:0] PAD0, PAD1, PAD2, PAD3;
  logic [1:0]  di_std, di_mt;

  always #5 MCLK = ~MCLK;

  snes_pad_responder #(.MULTITAP(0)) dut_std (
    .MCLK(MCLK), .RESET(RESET), .JOY_STRB(JOY_STRB), .JOY_CLK(JOY_CLK), .JOY_P6(JOY_P6),
    .PAD0(PAD0), .PAD1(PAD1), .PAD2(PAD2), .PAD3(PAD3), .JOY_DI(di_std));

  snes_pad_responder #(.MULTITAP(1)) dut_mt (
    .MCLK(MCLK), .RESET(RESET), .JOY_STRB(JOY_STRB), .JOY_CLK(JOY_CLK), .JOY_P6(JOY_P6),
    .PAD0(PAD0), .PAD1(PAD1), .PAD2(PAD2), .PAD3(PAD3), .JOY_DI(di_mt));

  typedef struct {
    int         cyc;
    logic [1:0] exp_std;
    logic [1:0] exp_mt;
    string      tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // Reference model: latched report word per pad and how many bits were read.
  logic [15:0] word_m [4];
  int          pos_std;
  int          pos_mt [4];

  always @(posedge MCLK) cyc <= cyc + 1;

  function automatic logic bit_at(input logic [15:0] w, input int p);
    return (p >= 16) ? 1'b1 : w[p];
  endfunction

  function automatic logic [1:0] map_std(input logic strb);
    if (strb) return {1'b0, PAD0[0]};
    return {1'b0, bit_at(word_m[0], pos_std)};
  endfunction

  function automatic logic [1:0] map_mt(input logic strb, input logic p6);
    if (strb) return {1'b1, PAD0[0]};
    if (p6) return {bit_at(word_m[1], pos_mt[1]), bit_at(word_m[0], pos_mt[0])};
    return {bit_at(word_m[3], pos_mt[3]), bit_at(word_m[2], pos_mt[2])};
  endfunction

  task automatic push(input int c, input logic [1:0] es, input logic [1:0] em, input string tag);
    exp_t e;
    e.cyc = c; e.exp_std = es; e.exp_mt = em; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic settle();
    tick(); tick();
    push(cyc, map_std(JOY_STRB), map_mt(JOY_STRB, JOY_P6), "steady");
    tick();
  endtask

  task automatic model_latch();
    word_m[0] = {4'b0000, PAD0};
    word_m[1] = {4'b0000, PAD1};
    word_m[2] = {4'b0000, PAD2};
    word_m[3] = {4'b0000, PAD3};
    pos_std = 0;
    for (int i = 0; i < 4; i++) pos_mt[i] = 0;
  endtask

  task automatic do_strobe(input logic [11:0] p0, input logic [11:0] p1,
                           input logic [11:0] p2, input logic [11:0] p3);
    tick();
    PAD0 = p0; PAD1 = p1; PAD2 = p2; PAD3 = p3;
    tick();
    JOY_STRB = 1'b1;
    push(cyc + 1, {1'b0, p0[0]}, {1'b1, p0[0]}, "latch");
    model_latch();
    tick(); tick();
    JOY_STRB = 1'b0;
    settle();
  endtask

  // Low phase, then rise together with the new pin-6 selection.
  task automatic do_pulse(input logic p6n);
    int n;
    tick();
    JOY_CLK = 1'b0;
    tick();
    JOY_CLK = 1'b1;
    JOY_P6  = p6n;
    n = cyc;
    push(n + 1, map_std(1'b0), map_mt(1'b0, p6n), "clk_hold");
    if (pos_std < 16) pos_std++;
    for (int i = 0; i < 4; i++) begin
      if (((i < 2) == p6n) && pos_mt[i] < 16) pos_mt[i]++;
    end
    push(n + 2, map_std(1'b0), map_mt(1'b0, p6n), "clk_bit");
    tick(); tick();
  endtask

  task automatic do_reset();
    tick();
    RESET = 1'b1;
    push(cyc + 1, 2'b00, 2'b00, "reset_di");
    tick();
    RESET = 1'b0;
    pos_std = 16;
    for (int i = 0; i < 4; i++) pos_mt[i] = 16;
    push(cyc + 1, map_std(JOY_STRB), map_mt(JOY_STRB, JOY_P6), "reset_done");
    tick();
    settle();
  endtask

  task automatic do_strobe_rise(input logic [11:0] p0);
    tick();
    PAD0 = p0;
    JOY_CLK = 1'b0;
    tick();
    JOY_STRB = 1'b1;
    JOY_CLK  = 1'b1;
    push(cyc + 1, {1'b0, p0[0]}, {1'b1, p0[0]}, "strb_rise");
    model_latch();
    tick(); tick();
    JOY_STRB = 1'b0;
    settle();
    do_pulse(JOY_P6);
  endtask

  task automatic set_p6(input logic v);
    tick();
    JOY_P6 = v;
    push(cyc + 1, map_std(1'b0), map_mt(1'b0, v), "p6_switch");
    settle();
  endtask

  // Monitor: compare both data lines whenever an expectation falls due
  always @(negedge MCLK) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc != cyc) begin
        total++; bad++;
        $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", mon_e.tag, mon_e.cyc, cyc);
      end else begin
        total++;
        if (di_std !== mon_e.exp_std) begin
          bad++;
          $display("FAIL std_%s: cyc=%0d got=%b want=%b", mon_e.tag, cyc, di_std, mon_e.exp_std);
        end
        total++;
        if (di_mt !== mon_e.exp_mt) begin
          bad++;
          $display("FAIL mt_%s: cyc=%0d got=%b want=%b", mon_e.tag, cyc, di_mt, mon_e.exp_mt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; JOY_STRB = 1'b0; JOY_CLK = 1'b1; JOY_P6 = 1'b1;
    PAD0 = 12'h000; PAD1 = 12'h000; PAD2 = 12'h000; PAD3 = 12'h000;
    for (int i = 0; i < 4; i++) begin
      word_m[i] = 16'h0000;
      pos_mt[i] = 16;
    end
    pos_std = 16;
    tick(); tick();
    push(cyc, 2'b00, 2'b00, "por");
    tick();
    RESET = 1'b0;
    push(cyc + 1, map_std(1'b0), map_mt(1'b0, JOY_P6), "por_done");
    tick();
    settle();

    // Standard report: B and A pressed, 17 reads
    do_strobe(12'h101, 12'h000, 12'h000, 12'h000);
    for (int k = 0; k < 17; k++) do_pulse(1'b1);

    // Reset in the middle of a report
    do_strobe(12'h0F5, 12'h3C1, 12'hA5A, 12'h5A5);
    for (int k = 0; k < 5; k++) do_pulse(1'b1);
    do_reset();
    do_pulse(1'b1);

    // Strobe and clock rise in the same cycle
    do_strobe_rise(12'h001);
    do_strobe_rise(12'hFFE);

    // Multitap pairs
    set_p6(1'b1);
    do_strobe(12'h000, 12'h002, 12'h000, 12'h800);
    do_pulse(1'b1);
    do_pulse(1'b1);
    set_p6(1'b0);
    for (int k = 0; k < 12; k++) do_pulse(1'b0);
    set_p6(1'b1);
    do_pulse(1'b1);

    // Randomized sequences
    for (int r = 0; r < 40; r++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op == 0) begin
        do_reset();
      end else if (op <= 2) begin
        do_strobe(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
      end else if (op == 3) begin
        do_strobe_rise(12'($urandom));
      end else begin
        int burst;
        burst = $urandom_range(1, 6);
        for (int k = 0; k < burst; k++) do_pulse(1'($urandom));
      end
    end

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) tick();
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations never checked", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
